user_bram_pipe: RTL and testbench
=================================

# user_bram_pipe

Fixed-latency, fully pipelined user-area BRAM that serves the Wishbone prefetch front end in the user project. Every strobed request (read or write) is accepted in the cycle it is presented and is acknowledged exactly N cycles later. One request per cycle is sustained with no backpressure, so the upstream prefetcher can stream up to N back-to-back reads. It models the external-memory delay seen by firmware executing from user BRAM.

## Interface
Parameters:
- N, 10, fixed request-to-ack latency in cycles; legal range 1..32
- ADDR_BITS, 13, word-address width; memory depth is 2^ADDR_BITS 32-bit words
- INIT_FILE, "counter.hex", hex image path; used only when the init feature is compiled in

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- stb  in  1  request strobe; one request is accepted per cycle in which it is high
- we  in  1  1 = write, 0 = read
- sel  in  4  byte enables; sel[i] covers dat_i[8i+7:8i]
- dat_i  in  32  write data
- addr  in  32  byte address; word index is addr[ADDR_BITS+1:2]
- ack  out  1  completion pulse, one cycle per accepted request
- dat_o  out  32  read data; valid only in a read-ack cycle, 0 otherwise

## Operation
- Acceptance: an edge with stb=1 and rst=0 accepts the request. There is no stall or ready signal.
- Write: memory is updated at the acceptance edge for each byte with sel[i]=1. A write with sel=0 changes no data but is still acked.
- Read: the memory word is sampled at the acceptance edge. Data and the read flag travel down an N-deep valid/we/data delay line.
- Ordering: acks are strictly in issue order. Read-after-write one cycle later returns the new data. There is no same-cycle conflict because only one request can be accepted per cycle.
- addr[1:0] and addr[31:ADDR_BITS+2] are ignored; upstream decodes 0x380xxxxx. Word addresses wrap modulo 2^ADDR_BITS.
- ack = valid at the last stage. dat_o = stage data when the last stage is a valid read, otherwise 32'h0.
- Reset: all delay-line valid bits clear, so in-flight requests are dropped and never acked. Memory contents are preserved. A stb present during the rst cycle is ignored and no write occurs.
- Reset values: ack=0, dat_o=0.

## Timing
- A request with stb high in cycle t produces ack high in cycle t+N, for exactly one cycle unless another request followed in cycle t+1.
- Throughput: 1 request/cycle. K consecutive strobes produce K consecutive ack cycles, t+N .. t+N+K-1.
- All outputs are registered from the delay line, with no combinational path from inputs. N=1 gives ack in the cycle after stb.
- Deassertion of rst: a stb in the first cycle after reset is accepted normally.

## Configuration
- USER_BRAM_PIPE_INIT_EN defined: the memory is preloaded at time zero from INIT_FILE with $readmemh. Reads of any location return the image until that location is overwritten.
- Not defined: no preload, and memory power-up contents are unspecified. Benches must write a location before reading it; the read-data check is then identical.

## Structure
- Package user_bram_pipe_pkg holds:
  - WORD_W=32 and BYTES=4
  - DEFAULT_LATENCY=10
  - typedef pipe_entry_t {valid, we, data[31:0]}
- Sub-module user_bram_pipe_delay is a generic N-stage shift line of pipe_entry_t with synchronous clear of valid bits. The top level holds the memory array, byte-write logic and the output mux.

## Test plan
- Write 0xDEADBEEF to 0x38000010 (sel=F) at t, read it at t+3 → ack at t+10 with dat_o=0, ack at t+13 with dat_o=0xDEADBEEF.
- Byte enables: preload 0xFFFFFFFF, write 0x11223344 with sel=0101, then read → 0xFF22FF44.
- Burst: 10 reads of 0x38000000..0x38000024 in cycles t..t+9 → ack high for cycles t+10..t+19, with data in address order and no gaps.
- Read-after-write: write 0xA5A5A5A5 at t, read the same word at t+1 → the read ack at t+11 returns 0xA5A5A5A5.
- Reset mid-flight: reads at t, t+1, t+2, then rst at t+4 → no ack through t+20. A later read of a previously written word returns the retained data N cycles after its strobe.
- Wrap: write 0x12345678 to 0x38000000 + 4·2^13, then read 0x38000000 → 0x12345678.

Source files
------------

// File: rtl/user_bram_pipe_pkg.sv
// Shared types and constants for the fixed-latency user BRAM pipeline.
package user_bram_pipe_pkg;

    localparam int WORD_W          = 32;
    localparam int BYTES           = 4;
    localparam int DEFAULT_LATENCY = 10;

    typedef struct packed {
        logic              valid;
        logic              we;
        logic [WORD_W-1:0] data;
    } pipe_entry_t;

endpackage

// File: rtl/user_bram_pipe_delay.sv
// Generic N-stage shift line of pipe entries; reset clears only the valid bits.
module user_bram_pipe_delay
    import user_bram_pipe_pkg::*;
#(
    parameter int N = DEFAULT_LATENCY
) (
    input  logic        clk,
    input  logic        rst,
    input  pipe_entry_t entry_i,
    output pipe_entry_t entry_o
);

    pipe_entry_t stage_q [N];

    // Payload shifts every cycle; on reset the valid bits override so in-flight requests vanish.
    always_ff @(posedge clk) begin
        stage_q[0] <= entry_i;
        for (int i = 1; i < N; i++) begin
            stage_q[i] <= stage_q[i-1];
        end
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                stage_q[i].valid <= 1'b0;
            end
        end
    end

    assign entry_o = stage_q[N-1];

endmodule

// File: rtl/user_bram_pipe.sv
// Fixed-latency pipelined user BRAM: every strobe is acked exactly N cycles later.
module user_bram_pipe
    import user_bram_pipe_pkg::*;
#(
    parameter int    N         = DEFAULT_LATENCY,
    parameter int    ADDR_BITS = 13,
    parameter string INIT_FILE = "counter.hex"
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stb,
    input  logic              we,
    input  logic [BYTES-1:0]  sel,
    input  logic [WORD_W-1:0] dat_i,
    input  logic [31:0]       addr,
    output logic              ack,
    output logic [WORD_W-1:0] dat_o
);

    localparam int DEPTH = 1 << ADDR_BITS;

    logic [WORD_W-1:0]    mem [DEPTH];
    logic [ADDR_BITS-1:0] wordIdx;
    logic                 accept;
    pipe_entry_t          entry_d;
    pipe_entry_t          tail;

    // Upstream already decoded the region, so the high and byte-lane address bits carry no meaning here.
    logic unused_addr;
    assign unused_addr = ^{addr[31:ADDR_BITS+2], addr[1:0]};

    localparam string unused_init_file = INIT_FILE;

    assign accept  = stb && !rst;
    assign wordIdx = addr[ADDR_BITS+1:2];

    always_ff @(posedge clk) begin
        if (accept && we) begin
            for (int b = 0; b < BYTES; b++) begin
                if (sel[b]) begin
                    mem[wordIdx][8*b +: 8] <= dat_i[8*b +: 8];
                end
            end
        end
    end

    // Read data is captured at the acceptance edge; writes carry no payload down the line.
    always_comb begin
        entry_d       = '0;
        entry_d.valid = accept;
        entry_d.we    = we;
        if (!we) begin
            entry_d.data = mem[wordIdx];
        end
    end

    user_bram_pipe_delay #(
        .N(N)
    ) u_delay (
        .clk    (clk),
        .rst    (rst),
        .entry_i(entry_d),
        .entry_o(tail)
    );

    assign ack   = tail.valid;
    assign dat_o = (tail.valid && !tail.we) ? tail.data : '0;

endmodule

// File: tb/tb_user_bram_pipe.sv
// Self-checking bench for user_bram_pipe: directed scenarios plus randomized traffic
// against a cycle-keyed reference model of memory contents and ack schedule.
module tb_user_bram_pipe;

    localparam int N         = 10;
    localparam int ADDR_BITS = 13;
    localparam int DEPTH     = 1 << ADDR_BITS;

    typedef struct {
        logic        s;
        logic        w;
        logic [3:0]  sel;
        logic [31:0] dat;
        logic [31:0] addr;
        logic        r;
    } stim_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] dat_i;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] dat_o;

    int total = 0;
    int bad   = 0;
    int edgeNo = 0;

    logic [31:0] modelMem [int];
    bit          expAckAt [int];
    logic [31:0] expDatAt [int];

    logic        obsAck, expAck;
    logic [31:0] obsDat, expDat;

    user_bram_pipe #(
        .N(N),
        .ADDR_BITS(ADDR_BITS)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .stb  (stb),
        .we   (we),
        .sel  (sel),
        .dat_i(dat_i),
        .addr (addr),
        .ack  (ack),
        .dat_o(dat_o)
    );

    always #5 clk = ~clk;

    function automatic stim_t mk(input logic s, input logic w, input logic [3:0] sl,
                                 input logic [31:0] d, input logic [31:0] a, input logic r);
        stim_t st;
        st.s = s; st.w = w; st.sel = sl; st.dat = d; st.addr = a; st.r = r;
        return st;
    endfunction

    function automatic stim_t idle();
        return mk(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0);
    endfunction

    // Drives one cycle, advances the reference model at the edge, and samples outputs at the next negedge.
    task automatic applyStimulus(input stim_t st);
        int          wi;
        int          k;
        int          dropQ[$];
        logic [31:0] word;
        stb = st.s; we = st.w; sel = st.sel; dat_i = st.dat; addr = st.addr; rst = st.r;
        @(posedge clk);
        edgeNo++;
        if (st.r) begin
            foreach (expAckAt[key]) if (key >= edgeNo) dropQ.push_back(key);
            foreach (dropQ[i]) begin
                expAckAt.delete(dropQ[i]);
                expDatAt.delete(dropQ[i]);
            end
        end else if (st.s) begin
            wi = int'((st.addr >> 2) % DEPTH);
            if (!modelMem.exists(wi)) modelMem[wi] = 'x;
            k = edgeNo + N - 1;
            expAckAt[k] = 1'b1;
            if (st.w) begin
                word = modelMem[wi];
                for (int b = 0; b < 4; b++) if (st.sel[b]) word[8*b +: 8] = st.dat[8*b +: 8];
                modelMem[wi] = word;
                expDatAt[k] = 32'h0;
            end else begin
                expDatAt[k] = modelMem[wi];
            end
        end
        @(negedge clk);
        obsAck = ack;
        obsDat = dat_o;
        if (expAckAt.exists(edgeNo)) begin
            expAck = 1'b1;
            expDat = expDatAt[edgeNo];
            expAckAt.delete(edgeNo);
            expDatAt.delete(edgeNo);
        end else begin
            expAck = 1'b0;
            expDat = 32'h0;
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(mk(1'b1, 1'b0, 4'hF, 32'h0, 32'h38000000, 1'b1));
            total++;
            if (obsAck !== 1'b0 || obsDat !== 32'h0) begin
                bad++;
                $display("[TB] FAIL reset cyc%0d ack=%b dat=%h want ack=0 dat=00000000", i, obsAck, obsDat);
            end
        end
    endtask

    task automatic test_write_read();
        stim_t q[$];
        logic  ackLog[$];
        logic [31:0] datLog[$];
        q.push_back(mk(1'b1, 1'b1, 4'hF, 32'hDEADBEEF, 32'h38000010, 1'b0));
        q.push_back(idle());
        q.push_back(idle());
        q.push_back(mk(1'b1, 1'b0, 4'hF, 32'h0, 32'h38000010, 1'b0));
        for (int i = 0; i < N + 2; i++) q.push_back(idle());
        foreach (q[i]) begin
            applyStimulus(q[i]);
            ackLog.push_back(obsAck);
            datLog.push_back(obsDat);
            total++;
            if (obsAck !== expAck || obsDat !== expDat) begin
                bad++;
                $display("[TB] FAIL wr_rd cyc%0d ack=%b dat=%h want ack=%b dat=%h", i, obsAck, obsDat, expAck, expDat);
            end
        end
        total++;
        if (ackLog[N-1] !== 1'b1 || datLog[N-1] !== 32'h0) begin
            bad++;
            $display("[TB] FAIL wr_ack ack=%b dat=%h want ack=1 dat=00000000", ackLog[N-1], datLog[N-1]);
        end
        total++;
        if (ackLog[N+2] !== 1'b1 || datLog[N+2] !== 32'hDEADBEEF) begin
            bad++;
            $display("[TB] FAIL rd_ack ack=%b dat=%h want ack=1 dat=deadbeef", ackLog[N+2], datLog[N+2]);
        end
    endtask

    task automatic test_byte_enables();
        stim_t q[$];
        logic  ackLog[$];
        logic [31:0] datLog[$];
        q.push_back(mk(1'b1, 1'b1, 4'hF, 32'hFFFFFFFF, 32'h38000020, 1'b0));
        q.push_back(mk(1'b1, 1'b1, 4'b0101, 32'h11223344, 32'h38000020, 1'b0));
        q.push_back(mk(1'b1, 1'b0, 4'hF, 32'h0, 32'h38000020, 1'b0));
        q.push_back(mk(1'b1, 1'b1, 4'h0, 32'h00000000, 32'h38000020, 1'b0));
        q.push_back(mk(1'b1, 1'b0, 4'hF, 32'h0, 32'h38000020, 1'b0));
        for (int i = 0; i < N + 1; i++) q.push_back(idle());
        foreach (q[i]) begin
            applyStimulus(q[i]);
            ackLog.push_back(obsAck);
            datLog.push_back(obsDat);
            total++;
            if (obsAck !== expAck || obsDat !== expDat) begin
                bad++;
                $display("[TB] FAIL bytes cyc%0d ack=%b dat=%h want ack=%b dat=%h", i, obsAck, obsDat, expAck, expDat);
            end
        end
        total++;
        if (ackLog[N+1] !== 1'b1 || datLog[N+1] !== 32'hFF22FF44) begin
            bad++;
            $display("[TB] FAIL sel_merge ack=%b dat=%h want ack=1 dat=ff22ff44", ackLog[N+1], datLog[N+1]);
        end
        total++;
        if (ackLog[N+3] !== 1'b1 || datLog[N+3] !== 32'hFF22FF44) begin
            bad++;
            $display("[TB] FAIL sel_zero ack=%b dat=%h want ack=1 dat=ff22ff44", ackLog[N+3], datLog[N+3]);
        end
    endtask

    task automatic test_back_to_back();
        stim_t q[$];
        logic  ackLog[$];
        logic [31:0] datLog[$];
        for (int i = 0; i < 10; i++)
            q.push_back(mk(1'b1, 1'b1, 4'hF, 32'hB0000000 + 32'(i), 32'h38000000 + 32'(4*i), 1'b0));
        for (int i = 0; i < 10; i++)
            q.push_back(mk(1'b1, 1'b0, 4'hF, 32'h0, 32'h38000000 + 32'(4*i), 1'b0));
        for (int i = 0; i < N + 2; i++) q.push_back(idle());
        foreach (q[i]) begin
            applyStimulus(q[i]);
            ackLog.push_back(obsAck);
            datLog.push_back(obsDat);
            total++;
            if (obsAck !== expAck || obsDat !== expDat) begin
                bad++;
                $display("[TB] FAIL burst cyc%0d ack=%b dat=%h want ack=%b dat=%h", i, obsAck, obsDat, expAck, expDat);
            end
        end
        for (int i = 0; i < 10; i++) begin
            total++;
            if (ackLog[10+i+N-1] !== 1'b1 || datLog[10+i+N-1] !== 32'hB0000000 + 32'(i)) begin
                bad++;
                $display("[TB] FAIL burst_rd%0d ack=%b dat=%h want ack=1 dat=%h", i,
                         ackLog[10+i+N-1], datLog[10+i+N-1], 32'hB0000000 + 32'(i));
            end
        end
        total++;
        if (ackLog[20+N-1] !== 1'b0) begin
            bad++;
            $display("[TB] FAIL burst_end ack=%b want ack=0", ackLog[20+N-1]);
        end
    endtask

    task automatic test_read_after_write();
        stim_t q[$];
        logic  ackLog[$];
        logic [31:0] datLog[$];
        q.push_back(mk(1'b1, 1'b1, 4'hF, 32'hA5A5A5A5, 32'h38000100, 1'b0));
        q.push_back(mk(1'b1, 1'b0, 4'hF, 32'h0, 32'h38000100, 1'b0));
        for (int i = 0; i < N + 1; i++) q.push_back(idle());
        foreach (q[i]) begin
            applyStimulus(q[i]);
            ackLog.push_back(obsAck);
            datLog.push_back(obsDat);
            total++;
            if (obsAck !== expAck || obsDat !== expDat) begin
                bad++;
                $display("[TB] FAIL raw cyc%0d ack=%b dat=%h want ack=%b dat=%h", i, obsAck, obsDat, expAck, expDat);
            end
        end
        total++;
        if (ackLog[N] !== 1'b1 || datLog[N] !== 32'hA5A5A5A5) begin
            bad++;
            $display("[TB] FAIL raw_data ack=%b dat=%h want ack=1 dat=a5a5a5a5", ackLog[N], datLog[N]);
        end
    endtask

    task automatic test_reset_midflight();
        stim_t q[$];
        logic  ackLog[$];
        logic [31:0] datLog[$];
        int    base;
        int    seen;
        q.push_back(mk(1'b1, 1'b1, 4'hF, 32'hCAFEF00D, 32'h38000200, 1'b0));
        for (int i = 0; i < N + 1; i++) q.push_back(idle());
        base = q.size();
        for (int i = 0; i < 3; i++) q.push_back(mk(1'b1, 1'b0, 4'hF, 32'h0, 32'h38000200, 1'b0));
        q.push_back(idle());
        q.push_back(mk(1'b1, 1'b1, 4'hF, 32'h0BADBAD0, 32'h38000200, 1'b1));
        for (int i = 0; i < 16; i++) q.push_back(idle());
        q.push_back(mk(1'b1, 1'b0, 4'hF, 32'h0, 32'h38000200, 1'b0));
        for (int i = 0; i < N + 1; i++) q.push_back(idle());
        foreach (q[i]) begin
            applyStimulus(q[i]);
            ackLog.push_back(obsAck);
            datLog.push_back(obsDat);
            total++;
            if (obsAck !== expAck || obsDat !== expDat) begin
                bad++;
                $display("[TB] FAIL rst_mid cyc%0d ack=%b dat=%h want ack=%b dat=%h", i, obsAck, obsDat, expAck, expDat);
            end
        end
        seen = 0;
        for (int i = base; i <= base + 20; i++) if (ackLog[i] !== 1'b0) seen++;
        total++;
        if (seen != 0) begin
            bad++;
            $display("[TB] FAIL rst_drop acks=%0d want acks=0", seen);
        end
        total++;
        if (ackLog[base+21+N-1] !== 1'b1 || datLog[base+21+N-1] !== 32'hCAFEF00D) begin
            bad++;
            $display("[TB] FAIL rst_retain ack=%b dat=%h want ack=1 dat=cafef00d",
                     ackLog[base+21+N-1], datLog[base+21+N-1]);
        end
    endtask

    task automatic test_wrap();
        stim_t q[$];
        logic  ackLog[$];
        logic [31:0] datLog[$];
        q.push_back(mk(1'b1, 1'b1, 4'hF, 32'h12345678, 32'h38000000 + 32'(4*DEPTH), 1'b0));
        q.push_back(mk(1'b1, 1'b0, 4'hF, 32'h0, 32'h38000000, 1'b0));
        for (int i = 0; i < N + 1; i++) q.push_back(idle());
        foreach (q[i]) begin
            applyStimulus(q[i]);
            ackLog.push_back(obsAck);
            datLog.push_back(obsDat);
            total++;
            if (obsAck !== expAck || obsDat !== expDat) begin
                bad++;
                $display("[TB] FAIL wrap cyc%0d ack=%b dat=%h want ack=%b dat=%h", i, obsAck, obsDat, expAck, expDat);
            end
        end
        total++;
        if (ackLog[N] !== 1'b1 || datLog[N] !== 32'h12345678) begin
            bad++;
            $display("[TB] FAIL wrap_data ack=%b dat=%h want ack=1 dat=12345678", ackLog[N], datLog[N]);
        end
    endtask

    // Random traffic over a pool of fully written words, with junk in the ignored address bits and occasional resets.
    task automatic test_random();
        stim_t q[$];
        logic [31:0] a;
        for (int p = 0; p < 16; p++)
            q.push_back(mk(1'b1, 1'b1, 4'hF, $urandom, 32'h38000000 + 32'(4*(256+p)), 1'b0));
        for (int i = 0; i < 400; i++) begin
            a = ($urandom & 32'hFFFF8003) | (32'(256 + $urandom_range(0, 15)) << 2);
            q.push_back(mk(($urandom % 4) != 0, ($urandom % 3) == 0, 4'($urandom), $urandom, a,
                           ($urandom % 60) == 0));
        end
        for (int i = 0; i < N + 1; i++) q.push_back(idle());
        foreach (q[i]) begin
            applyStimulus(q[i]);
            total++;
            if (obsAck !== expAck || obsDat !== expDat) begin
                bad++;
                $display("[TB] FAIL random cyc%0d ack=%b dat=%h want ack=%b dat=%h", i, obsAck, obsDat, expAck, expDat);
            end
        end
    endtask

    initial begin
        rst = 1'b1; stb = 1'b0; we = 1'b0; sel = 4'h0; dat_i = 32'h0; addr = 32'h0;
        test_reset();
        test_write_read();
        test_byte_enables();
        test_back_to_back();
        test_read_after_write();
        test_reset_midflight();
        test_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
